// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared cpu package with MDU op encodings, FSM states and default latencies.
// MDU_MADD_EN adds MADD/MSUB to the set of multi-cycle ops.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    function automatic logic is_div(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic is_multi(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return op != OP_MTHI && op != OP_MTLO;
`else
        return op <= OP_DIVU;
`endif
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// mdu_alu: combinational next-{hi,lo} for the latched MDU op; returns current {hi,lo} when nothing is written.
// MADD/MSUB accumulation only exists when MDU_MADD_EN is defined.
module mdu_alu
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_hilo
);

    logic [63:0] w_hilo;
    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_rt_zero;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    assign w_hilo    = {i_hi, i_lo};
    assign w_sprod   = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_uprod   = {32'b0, i_rs} * {32'b0, i_rt};
    assign w_rt_zero = i_rt == 32'd0;
    assign w_uq      = w_rt_zero ? 32'd0 : i_rs / i_rt;
    assign w_ur      = w_rt_zero ? 32'd0 : i_rs % i_rt;

    // Signed divide on magnitudes keeps -2^31 / -1 well defined (wraps to 0x80000000).
    assign w_rs_mag  = i_rs[31] ? -i_rs : i_rs;
    assign w_rt_mag  = i_rt[31] ? -i_rt : i_rt;
    assign w_sq_mag  = w_rt_zero ? 32'd0 : w_rs_mag / w_rt_mag;
    assign w_sr_mag  = w_rt_zero ? 32'd0 : w_rs_mag % w_rt_mag;
    assign w_sq      = (i_rs[31] ^ i_rt[31]) ? -w_sq_mag : w_sq_mag;
    assign w_sr      = i_rs[31] ? -w_sr_mag : w_sr_mag;

    always_comb begin
        o_hilo = w_hilo;
        case (i_op)
            OP_MULT:  o_hilo = w_sprod;
            OP_MULTU: o_hilo = w_uprod;
            OP_DIV:   o_hilo = w_rt_zero ? w_hilo : {w_sr, w_sq};
            OP_DIVU:  o_hilo = w_rt_zero ? w_hilo : {w_ur, w_uq};
`ifdef MDU_MADD_EN
            OP_MADD:  o_hilo = w_hilo + w_sprod;
            OP_MSUB:  o_hilo = w_hilo - w_sprod;
`endif
            default:  o_hilo = w_hilo;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit control with IDLE/RUN FSM, latency counter and HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MSUB (ops 6/7); otherwise they are ignored.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        w_accept;
    logic        w_multi;
    logic [63:0] w_next;

    assign w_accept  = start & ~flush & (r_state == ST_IDLE);
    assign w_multi   = is_multi(op);
    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign stall_req = ~reset & md_use & (r_busy | (start & ~flush & w_multi));

    mdu_alu u_alu (
        .i_op   (r_op),
        .i_rs   (r_rs),
        .i_rt   (r_rt),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .o_hilo (w_next)
    );

    // Flush is not looked at in RUN: the issuing instruction has already left EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_rs    <= 32'd0;
            r_rt    <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept && w_multi) begin
                r_op    <= op;
                r_rs    <= rs_val;
                r_rt    <= rt_val;
                r_cnt   <= is_div(op) ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
            end else if (w_accept && op == OP_MTHI) begin
                r_hi <= rs_val;
            end else if (w_accept && op == OP_MTLO) begin
                r_lo <= rs_val;
            end
        end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                {r_hi, r_lo} <= w_next;
                r_state      <= ST_IDLE;
                r_busy       <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MUL_CYCLES, 5, busy cycles for mult/multu/madd/msub.
- DIV_CYCLES, 10, busy cycles for div/divu.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, EX-stage MDU instruction valid this cycle.
- op, in, 3, 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- rs_val, in, 32, forwarded rs operand.
- rt_val, in, 32, forwarded rt operand.
- flush, in, 1, exception/interrupt kill of the EX instruction this cycle.
- md_use, in, 1, D-stage instruction is an MDU op or mfhi/mflo.
- busy, out, 1, multi-cycle operation in progress.
- stall_req, out, 1, freeze PC/D and clear E, to the control layer.
- hi, out, 32, HI register.
- lo, out, 32, LO register.

Function
REQ-003 The block SHALL be a 2-state FSM: IDLE and RUN, with a 4-bit down-counter cnt.
REQ-004 An accepted start SHALL be start=1, flush=0 and state IDLE; any other start SHALL be ignored with no state change.
REQ-005 An accepted start with a multi-cycle op SHALL latch op, rs_val and rt_val, then enter RUN with cnt = MUL_CYCLES or DIV_CYCLES.
- busy SHALL be 1 from the next cycle.
REQ-006 In RUN, cnt SHALL decrement each cycle.
- In the cycle cnt==1, hi/lo SHALL be written with the result and the FSM SHALL return to IDLE.
- busy SHALL be 1 for exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-007 Result rules:
- MULT: {hi,lo} = signed 64-bit product.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV: lo = signed quotient, hi = signed remainder, truncation toward zero; remainder takes the sign of the dividend.
- DIVU: lo = unsigned quotient, hi = unsigned remainder.
REQ-008 Divide with rt_val==0 SHALL run the full DIV_CYCLES and leave hi/lo unchanged.
REQ-009 MTHI/MTLO accepted in IDLE SHALL write rs_val to hi/lo at the next edge, with busy staying 0.
REQ-010 stall_req SHALL be combinational: md_use & (busy | (start & ~flush & op is multi-cycle)).
REQ-011 flush asserted while in RUN SHALL NOT cancel the operation, because the issuing instruction has already retired past EX.
REQ-012 hi/lo outputs SHALL change only at result write or at MTHI/MTLO.

Reset
REQ-013 When reset=1 at a rising edge, the block SHALL set state IDLE, cnt 0, busy 0, hi 0, lo 0 and clear the latched operands.
- stall_req SHALL be 0 during reset.
REQ-014 Reset mid-RUN SHALL abort the operation with no hi/lo write, and reset SHALL take priority over start.

Configuration
REQ-015 With MDU_MADD_EN defined, MADD/MSUB SHALL be supported:
- MADD: {hi,lo} = {hi,lo} + signed(rs*rt).
- MSUB: {hi,lo} = {hi,lo} - signed(rs*rt).
- Both SHALL use MUL_CYCLES, and the accumulation SHALL use the hi/lo values at completion.
REQ-016 Without MDU_MADD_EN, op 6/7 SHALL be ignored like an invalid start: no busy, no stall, no hi/lo change.

Structure
REQ-017 The op encodings, the IDLE/RUN state type and the default cycle counts SHALL live in the shared cpu package; the control layer SHALL use the same op constants.
REQ-018 The arithmetic SHALL be one combinational sub-module, mdu_alu, that takes the latched op, operands and current hi/lo and returns the 64-bit next {hi,lo}; the FSM and counter SHALL stay in mdu_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- MULT rs=0xFFFFFFFF, rt=2 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with rt=0 -> busy for 10 cycles, hi/lo unchanged.
- MULT in flight with md_use=1 (mflo in D) -> stall_req=1 for every busy cycle, dropping to 0 in the cycle after lo is written. start with flush=1 -> busy stays 0 and hi/lo are unchanged.
- MTHI rs=0x12345678 -> hi=0x12345678 next cycle, busy never 1. A second start issued while busy -> ignored, with the original result intact.
- reset asserted on cycle 3 of a DIV -> next cycle busy=0, hi=lo=0, and no later write occurs.
- With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, MADD 1*1 -> hi=1, lo=0. Without MDU_MADD_EN -> no change and busy stays 0.
